debounce_pulse_multi: RTL and testbench

Parametrised multi-channel successor to the single-switch manual-clock debouncer. Each channel synchronises a raw board switch/button, debounces it with a configurable stable-time counter, and emits single-cycle press, release and optional auto-repeat pulses in the CLKFPGA domain. It feeds manual single-step clocking and user-control inputs of the processor datapath.

---
 rtl/debounce_pulse_multi.sv | 138 +++++++++++++
 tb/tb_debounce_pulse_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse_multi.sv
// Multi-channel switch debouncer: per-channel 2-flop sync, stable-time filter,
// and one-cycle press / release / auto-repeat pulses in the CLKFPGA domain.
module debounce_pulse_multi #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 26,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic                CLKFPGA,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] Chave,
    input  logic [CHANNELS-1:0] RepeatEn,
    output logic [CHANNELS-1:0] Debounced,
    output logic [CHANNELS-1:0] Pulse,
    output logic [CHANNELS-1:0] Release
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    assign raw = Chave ^ {CHANNELS{ACTIVE_LOW}};

    always_ff @(posedge CLKFPGA or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic             deb_q;
        logic             pulse_q;
        logic             rel_q;
        logic [CNT_W-1:0] db_cnt;
        logic [CNT_W-1:0] timer;
        state_t           state;
        logic             accept;
        logic             rise;
        logic             fall;

        // Level change is accepted on the same edge the FSM reacts to it,
        // so Pulse/Release line up with the Debounced transition.
        assign accept = (sync2[ch] != deb_q) && (db_cnt == DB_LAST);
        assign rise   = accept & sync2[ch];
        assign fall   = accept & ~sync2[ch];

        assign Debounced[ch] = deb_q;
        assign Pulse[ch]     = pulse_q;
        assign Release[ch]   = rel_q;

        always_ff @(posedge CLKFPGA or posedge Reset) begin
            if (Reset) begin
                deb_q  <= 1'b0;
                db_cnt <= '0;
            end else if (sync2[ch] == deb_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                deb_q  <= sync2[ch];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end

        always_ff @(posedge CLKFPGA or posedge Reset) begin
            if (Reset) begin
                state   <= IDLE;
                timer   <= '0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (rise) begin
                            pulse_q <= 1'b1;
                            timer   <= '0;
                            state   <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (fall) begin
                            rel_q <= 1'b1;
                            timer <= '0;
                            state <= IDLE;
                        end else if (!RepeatEn[ch]) begin
                            timer <= '0;
                        end else if (timer == RD_LAST) begin
                            pulse_q <= 1'b1;
                            timer   <= '0;
                            state   <= REPEAT;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        // Release takes priority over a coincident repeat expiry.
                        if (fall) begin
                            rel_q <= 1'b1;
                            timer <= '0;
                            state <= IDLE;
                        end else if (!RepeatEn[ch]) begin
                            timer <= '0;
                            state <= DELAY;
                        end else if (timer == RP_LAST) begin
                            pulse_q <= 1'b1;
                            timer   <= '0;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    default: begin
                        timer <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debounce_pulse_multi.sv
// Directed vector bench for debounce_pulse_multi (2 channels, short timings)
// plus an inverted-input instance.
module tb_debounce_pulse_multi;

    localparam int unsigned CH = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] chave, ren, deb, pulse, rel;
    logic [CH-1:0] chave_al, ren_al, deb_al, pulse_al, rel_al;

    always #5 clk = ~clk;

    debounce_pulse_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .CNT_W(CW), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .CLKFPGA(clk), .Reset(rst), .Chave(chave), .RepeatEn(ren),
        .Debounced(deb), .Pulse(pulse), .Release(rel)
    );

    debounce_pulse_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .CNT_W(CW), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .CLKFPGA(clk), .Reset(rst), .Chave(chave_al), .RepeatEn(ren_al),
        .Debounced(deb_al), .Pulse(pulse_al), .Release(rel_al)
    );

    typedef struct {
        logic [1:0] chave;
        logic [1:0] ren;
        logic [1:0] deb;
        logic [1:0] pulse;
        logic [1:0] rel;
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_miss = 0;

    function automatic void push(logic [1:0] c, logic [1:0] r, logic [1:0] d,
                                 logic [1:0] p, logic [1:0] l);
        vec_t v;
        v.chave = c; v.ren = r; v.deb = d; v.pulse = p; v.rel = l;
        vq.push_back(v);
    endfunction

    // Input level change held for n cycles; accepted on the 6th sampled edge.
    function automatic void step(logic [1:0] prev, logic [1:0] nxt,
                                 logic [1:0] r, int n);
        for (int i = 0; i < n; i++)
            push(nxt, r, (i < 5) ? prev : nxt,
                 (i == 5) ? (nxt & ~prev) : 2'b00,
                 (i == 5) ? (prev & ~nxt) : 2'b00);
    endfunction

    task automatic check(string name, logic [1:0] act, logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_queue(string tag);
        for (int i = 0; i < vq.size(); i++) begin
            chave = vq[i].chave;
            ren   = vq[i].ren;
            @(posedge clk);
            #1;
            n_vec++;
            check($sformatf("%s[%0d].Debounced", tag, i), deb,   vq[i].deb);
            check($sformatf("%s[%0d].Pulse",     tag, i), pulse, vq[i].pulse);
            check($sformatf("%s[%0d].Release",   tag, i), rel,   vq[i].rel);
        end
        vq.delete();
    endtask

    initial begin
        rst = 1'b1; chave = 2'b00; ren = 2'b00;
        chave_al = 2'b11; ren_al = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset.Debounced", deb, 2'b00);
        check("reset.Pulse", pulse, 2'b00);
        check("reset.Release", rel, 2'b00);
        check("reset.al_Debounced", deb_al, 2'b00);
        rst = 1'b0;

        // Press both; stop right after the press pulse is registered.
        step(2'b00, 2'b11, 2'b00, 6);
        run_queue("press_both");

        // Asynchronous reset mid-cycle while held with Pulse high.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset.Debounced", deb, 2'b00);
        check("async_reset.Pulse", pulse, 2'b00);
        check("async_reset.Release", rel, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Still held: fresh press, no release for the interrupted press.
        step(2'b00, 2'b11, 2'b00, 7);
        step(2'b11, 2'b00, 2'b00, 7);
        run_queue("reset_rehold");

        // Bounce 1,0,1,0 then held from sample 4 -> accepted at edge 9.
        for (int i = 0; i < 11; i++) begin
            logic [1:0] c;
            c = (i == 1 || i == 3) ? 2'b00 : 2'b01;
            push(c, 2'b00, (i >= 9) ? 2'b01 : 2'b00,
                 (i == 9) ? 2'b01 : 2'b00, 2'b00);
        end
        step(2'b01, 2'b00, 2'b00, 7);
        run_queue("bounce");

        // Auto-repeat: press at 5, repeats 15,18,...,42; release at 45 beats expiry.
        for (int i = 0; i < 47; i++) begin
            logic p;
            p = (i == 5) || (i >= 15 && i <= 42 && ((i - 15) % 3) == 0);
            push((i < 40) ? 2'b01 : 2'b00, 2'b01,
                 (i >= 5 && i < 45) ? 2'b01 : 2'b00,
                 {1'b0, p}, (i == 45) ? 2'b01 : 2'b00);
        end
        run_queue("repeat_on");

        // Repeat enabled late (first sampled at 21) -> repeats 30,33,36;
        // disabled on the expiry edge 39 -> no pulse; release at 43.
        for (int i = 0; i < 45; i++) begin
            logic p;
            p = (i == 5) || (i == 30) || (i == 33) || (i == 36);
            push((i < 38) ? 2'b01 : 2'b00,
                 (i >= 21 && i < 39) ? 2'b01 : 2'b00,
                 (i >= 5 && i < 43) ? 2'b01 : 2'b00,
                 {1'b0, p}, (i == 43) ? 2'b01 : 2'b00);
        end
        run_queue("repeat_late");

        // Channel 0 press and channel 1 release on the same edge.
        step(2'b00, 2'b10, 2'b00, 7);
        step(2'b10, 2'b01, 2'b00, 7);
        step(2'b01, 2'b00, 2'b00, 7);
        run_queue("cross");

        // Inverted-input instance: pin 0 pulled low is a press.
        check("al_idle.Debounced", deb_al, 2'b00);
        chave_al = 2'b10;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            check($sformatf("al_press[%0d].Debounced", i), deb_al, (i >= 5) ? 2'b01 : 2'b00);
            check($sformatf("al_press[%0d].Pulse", i), pulse_al, (i == 5) ? 2'b01 : 2'b00);
            check($sformatf("al_press[%0d].Release", i), rel_al, 2'b00);
        end
        chave_al = 2'b11;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            check($sformatf("al_rel[%0d].Debounced", i), deb_al, (i >= 5) ? 2'b00 : 2'b01);
            check($sformatf("al_rel[%0d].Pulse", i), pulse_al, 2'b00);
            check($sformatf("al_rel[%0d].Release", i), rel_al, (i == 5) ? 2'b01 : 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
